// File: rtl/axi4_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi4_arb_pkg
// Summary  : Shared types and constants for the AXI4 write-path arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_DATA_W = 32;
    localparam int SIZE_W     = 3;

    // Payload widths for the default configuration
    localparam int AW_PLD_W = DEF_ADDR_W + DEF_LEN_W + SIZE_W;
    localparam int W_PLD_W  = DEF_DATA_W + 1;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi4_wr_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Summary  : Combinational round-robin pick; scans last_grant+1 upward.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NM    = 2,
    parameter int IDX_W = $clog2(NM)
) (
    input  logic [NM-1:0]    req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NM-1:0]    gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NM; k++) begin
            w_cand = IDX_W'((int'(last_grant) + k) % NM);
            if (!valid && req[w_cand]) begin
                valid        = 1'b1;
                gnt_idx      = w_cand;
                gnt[w_cand]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wr_arbiter
// Summary  : Round-robin sharing of one AXI4 slave write path (AW/W/B)
//            between NM masters, one whole burst at a time.
// Options  : AXI4_ARB_WLAST_CHECK_EN - generate WLAST from AWLEN and flag
//            master WLAST mismatches on wlast_err.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_wr_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int NM     = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    input  logic [NM*(ADDR_W+LEN_W+SIZE_W)-1:0]   m_aw_pld,
    input  logic [NM-1:0]                         m_aw_valid,
    output logic [NM-1:0]                         m_aw_ready,
    input  logic [NM*(DATA_W+1)-1:0]              m_w_pld,
    input  logic [NM-1:0]                         m_w_valid,
    output logic [NM-1:0]                         m_w_ready,
    output logic [1:0]                            m_bresp,
    output logic [NM-1:0]                         m_bvalid,
    input  logic [NM-1:0]                         m_bready,
    output logic [ADDR_W+LEN_W+SIZE_W-1:0]        s_aw_pld,
    output logic                                  s_aw_valid,
    input  logic                                  s_aw_ready,
    output logic [DATA_W:0]                       s_w_pld,
    output logic                                  s_w_valid,
    input  logic                                  s_w_ready,
    input  logic [1:0]                            s_bresp,
    input  logic                                  s_bvalid,
    output logic                                  s_bready,
    output logic [NM-1:0]                         grant,
    output logic                                  busy,
    output logic                                  wlast_err
);

    localparam int c_aw_w  = ADDR_W + LEN_W + SIZE_W;
    localparam int c_w_w   = DATA_W + 1;
    localparam int c_idx_w = $clog2(NM);

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic [NM-1:0]        r_grant;
    logic [c_idx_w-1:0]   r_gidx;
    logic [c_idx_w-1:0]   r_last;

    logic [NM-1:0]        w_arb_gnt;
    logic [c_idx_w-1:0]   w_arb_idx;
    logic                 w_arb_valid;

    logic [c_aw_w-1:0]    w_aw_pld_a [NM];
    logic [c_w_w-1:0]     w_w_pld_a  [NM];

    logic                 w_sel_awv;
    logic                 w_sel_wv;
    logic                 w_sel_wlast;
    logic                 w_sel_bready;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_b_hs;
    logic                 w_last;

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_unpack
            assign w_aw_pld_a[gi] = m_aw_pld[gi*c_aw_w +: c_aw_w];
            assign w_w_pld_a[gi]  = m_w_pld[gi*c_w_w +: c_w_w];
        end
    endgenerate

    rr_arbiter #(
        .NM    (NM),
        .IDX_W (c_idx_w)
    ) u_rr (
        .req        (m_aw_valid),
        .last_grant (r_last),
        .gnt        (w_arb_gnt),
        .gnt_idx    (w_arb_idx),
        .valid      (w_arb_valid)
    );

    assign w_sel_awv    = m_aw_valid[r_gidx];
    assign w_sel_wv     = m_w_valid[r_gidx];
    assign w_sel_wlast  = w_w_pld_a[r_gidx][0];
    assign w_sel_bready = m_bready[r_gidx];

    assign w_aw_hs = (r_state == ADDR) && w_sel_awv && s_aw_ready;
    assign w_w_hs  = (r_state == DATA) && w_sel_wv  && s_w_ready;
    assign w_b_hs  = (r_state == RESP) && s_bvalid  && w_sel_bready;

`ifdef AXI4_ARB_WLAST_CHECK_EN
    logic [LEN_W-1:0] r_awlen;
    logic [LEN_W-1:0] r_beat;
    logic             r_wlast_err;

    // Burst end comes from the beat count, not from the master's WLAST
    assign w_last    = (r_beat == r_awlen);
    assign wlast_err = r_wlast_err;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awlen     <= '0;
            r_beat      <= '0;
            r_wlast_err <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_awlen <= w_aw_pld_a[r_gidx][SIZE_W +: LEN_W];
                r_beat  <= '0;
            end else if (w_w_hs) begin
                r_beat  <= r_beat + LEN_W'(1);
            end
            if (w_w_hs && (w_sel_wlast != w_last)) begin
                r_wlast_err <= 1'b1;
            end
        end
    end
`else
    assign w_last    = w_sel_wlast;
    assign wlast_err = 1'b0;
`endif

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Owner tracking; last_grant only advances once a burst completes
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= c_idx_w'(NM - 1);
        end else begin
            if ((r_state == IDLE) && w_arb_valid) begin
                r_grant <= w_arb_gnt;
                r_gidx  <= w_arb_idx;
            end else if (w_b_hs) begin
                r_grant <= '0;
                r_last  <= r_gidx;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_arb_valid)       w_next = ADDR;
            ADDR:    if (w_aw_hs)           w_next = DATA;
            DATA:    if (w_w_hs && w_last)  w_next = RESP;
            RESP:    if (w_b_hs)            w_next = IDLE;
            default:                        w_next = IDLE;
        endcase
    end

    // Output routing: only the owner's channel of the current phase is open
    always_comb begin
        m_aw_ready = '0;
        m_w_ready  = '0;
        m_bvalid   = '0;
        s_aw_pld   = '0;
        s_aw_valid = 1'b0;
        s_w_pld    = '0;
        s_w_valid  = 1'b0;
        s_bready   = 1'b0;
        case (r_state)
            ADDR: begin
                s_aw_pld           = w_aw_pld_a[r_gidx];
                s_aw_valid         = w_sel_awv;
                m_aw_ready[r_gidx] = s_aw_ready;
            end
            DATA: begin
                s_w_pld           = {w_w_pld_a[r_gidx][c_w_w-1:1], w_last};
                s_w_valid         = w_sel_wv;
                m_w_ready[r_gidx] = s_w_ready;
            end
            RESP: begin
                m_bvalid[r_gidx] = s_bvalid;
                s_bready         = w_sel_bready;
            end
            default: ;
        endcase
    end

    assign m_bresp = s_bresp;
    assign grant   = r_grant;
    assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire
